// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, funct3 codes,
// byte-mask and alignment helpers.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // funct3[1:0] encodes the access size for every legal code.
    function automatic logic [7:0] size_mask(input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    return 8'h01;
            2'd1:    return 8'h03;
            2'd2:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_mask(input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    return 3'b000;
            2'd1:    return 3'b001;
            2'd2:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    function automatic logic f3_illegal(input logic [2:0] f3, input logic is_store,
                                        input logic rv64);
        logic bad;
        bad = (f3 == 3'b111);
        if (!rv64 && (f3 == F3_D || f3 == F3_WU))
            bad = 1'b1;
        if (is_store && f3[2])
            bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory req/ack port between the load/store unit (master) and memory (slave).
interface load_store_unit_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic                req;
    logic                we;
    logic [ADDR_W-1:0]   addr;
    logic [XLEN-1:0]     wdata;
    logic [XLEN/8-1:0]   be;
    logic [XLEN-1:0]     rdata;
    logic                ack;

    modport master (output req, we, addr, wdata, be, input rdata, ack);
    modport slave  (input req, we, addr, wdata, be, output rdata, ack);
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store shift and byte enables, plus load
// extraction with sign/zero extension.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int  XLEN   = 32,
    localparam int LANE_W = $clog2(XLEN/8)
) (
    input  logic [2:0]        funct3_i,
    input  logic [LANE_W-1:0] lane_i,
    input  logic [XLEN-1:0]   store_data_i,
    input  logic [XLEN-1:0]   rdata_i,
    output logic [XLEN-1:0]   wdata_o,
    output logic [XLEN/8-1:0] be_o,
    output logic [XLEN-1:0]   load_data_o
);
    logic [LANE_W+2:0] shamt;
    logic [XLEN-1:0]   shifted;

    assign shamt   = {lane_i, 3'b000};
    assign wdata_o = store_data_i << shamt;
    assign be_o    = (XLEN/8)'(size_mask(funct3_i)) << lane_i;
    assign shifted = rdata_i >> shamt;

    always_comb begin
        load_data_o = shifted;
        case (funct3_i)
            F3_B:    load_data_o = XLEN'($signed(shifted[7:0]));
            F3_BU:   load_data_o = XLEN'(shifted[7:0]);
            F3_H:    load_data_o = XLEN'($signed(shifted[15:0]));
            F3_HU:   load_data_o = XLEN'(shifted[15:0]);
            F3_W:    load_data_o = XLEN'($signed(shifted[31:0]));
            F3_WU:   load_data_o = XLEN'(shifted[31:0]);
            F3_D:    load_data_o = shifted;
            default: load_data_o = shifted;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Multicycle RV32I/RV64I load/store datapath with req/ack memory port and ack timeout.
// Optional: define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning them.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              is_store_i,
    input  logic [2:0]        funct3_i,
    input  logic [XLEN-1:0]   base_i,
    input  logic [XLEN-1:0]   offset_i,
    input  logic [XLEN-1:0]   store_data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [XLEN-1:0]   load_data_o,
    load_store_unit_if.master mem
);
    localparam int LANE_W = $clog2(XLEN/8);
    localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    lsu_state_e        state_q, state_d;
    logic              is_store_q, is_store_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   store_data_q, store_data_d;
    logic [XLEN-1:0]   load_data_q, load_data_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] eff_addr;
    logic [ADDR_W-1:0] aligned_addr;
    logic              reject;
    logic              in_req;
    logic [XLEN-1:0]   lane_wdata;
    logic [XLEN/8-1:0] lane_be;
    logic [XLEN-1:0]   lane_load;

    assign eff_addr     = ADDR_W'(base_i + offset_i);
    assign aligned_addr = {eff_addr[ADDR_W-1:3], eff_addr[2:0] & ~align_mask(funct3_i)};

`ifdef LSU_MISALIGN_TRAP_EN
    assign reject = f3_illegal(funct3_i, is_store_i, XLEN == 64) ||
                    (|(eff_addr[2:0] & align_mask(funct3_i)));
`else
    assign reject = f3_illegal(funct3_i, is_store_i, XLEN == 64);
`endif

    lsu_lane_align #(.XLEN(XLEN)) u_lane_align (
        .funct3_i     (funct3_q),
        .lane_i       (addr_q[LANE_W-1:0]),
        .store_data_i (store_data_q),
        .rdata_i      (mem.rdata),
        .wdata_o      (lane_wdata),
        .be_o         (lane_be),
        .load_data_o  (lane_load)
    );

    always_comb begin
        state_d      = state_q;
        is_store_d   = is_store_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        store_data_d = store_data_q;
        load_data_d  = load_data_q;
        wait_d       = wait_q;
        err_d        = err_q;
        case (state_q)
            IDLE: begin
                err_d = 1'b0;
                if (start_i) begin
                    is_store_d   = is_store_i;
                    funct3_d     = funct3_i;
                    addr_d       = aligned_addr;
                    store_data_d = store_data_i;
                    wait_d       = '0;
                    if (reject) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (mem.ack) begin
                    if (!is_store_q)
                        load_data_d = lane_load;
                    state_d = DONE;
                end else begin
                    wait_d = wait_q + 1'b1;
                    // The counter covers the cycle just ending, so compare post-increment.
                    if (MAX_WAIT != 0 && (32'(wait_q) + 32'd1) == 32'(MAX_WAIT)) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            is_store_q   <= 1'b0;
            funct3_q     <= '0;
            addr_q       <= '0;
            store_data_q <= '0;
            load_data_q  <= '0;
            wait_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            is_store_q   <= is_store_d;
            funct3_q     <= funct3_d;
            addr_q       <= addr_d;
            store_data_q <= store_data_d;
            load_data_q  <= load_data_d;
            wait_q       <= wait_d;
            err_q        <= err_d;
        end
    end

    // Bus outputs decode straight from the state register so reset clears them at once.
    assign in_req      = (state_q == REQ);
    assign mem.req     = in_req;
    assign mem.we      = in_req && is_store_q;
    assign mem.addr    = addr_q;
    assign mem.be      = in_req ? lane_be : '0;
    assign mem.wdata   = in_req ? lane_wdata : '0;

    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);
    assign error_o     = (state_q == DONE) && err_q;
    assign load_data_o = load_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed-vector bench for load_store_unit (XLEN=32, MAX_WAIT=4) with an ack-delay memory stub.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] base = '0;
    logic [31:0] offset = '0;
    logic [31:0] store_data = '0;
    logic        busy, done, error;
    logic [31:0] load_data;

    int checks = 0;
    int errors = 0;

    load_store_unit_if #(.XLEN(32), .ADDR_W(32)) mem_bus ();

    load_store_unit #(.XLEN(32), .ADDR_W(32), .MAX_WAIT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .is_store_i   (is_store),
        .funct3_i     (funct3),
        .base_i       (base),
        .offset_i     (offset),
        .store_data_i (store_data),
        .busy_o       (busy),
        .done_o       (done),
        .error_o      (error),
        .load_data_o  (load_data),
        .mem          (mem_bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, obs);
        end
    endtask

    // One operation: start at a negedge, ack in REQ cycle number ack_dly (0-based).
    // lat counts cycles from the start-sampling edge to the cycle where done is seen.
    task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] b,
                         input logic [31:0] o, input logic [31:0] sd, input logic [31:0] rd,
                         input int ack_dly, output int req_cycles, output int lat,
                         output logic [31:0] addr_s, output logic [3:0] be_s,
                         output logic [31:0] wdata_s, output logic we_s,
                         output logic done_s, output logic err_s, output logic busy_s);
        @(negedge clk);
        start = 1'b1; is_store = st; funct3 = f3; base = b; offset = o; store_data = sd;
        mem_bus.rdata = rd;
        @(negedge clk);
        start = 1'b0;
        req_cycles = 0; lat = 0;
        addr_s = '0; be_s = '0; wdata_s = '0; we_s = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                lat = i + 1;
                break;
            end
            if (mem_bus.req) begin
                addr_s = mem_bus.addr; be_s = mem_bus.be;
                wdata_s = mem_bus.wdata; we_s = mem_bus.we;
                if (req_cycles == ack_dly) mem_bus.ack = 1'b1;
                req_cycles++;
            end
            @(negedge clk);
            mem_bus.ack = 1'b0;
        end
        done_s = done; err_s = error; busy_s = busy;
    endtask

    int          rq, lt;
    logic [31:0] a_s, wd_s;
    logic [3:0]  be_s;
    logic        we_s, dn_s, er_s, bz_s;

    initial begin
        mem_bus.rdata = '0;
        mem_bus.ack   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy",  busy, 0);
        check("rst_done",  done, 0);
        check("rst_error", error, 0);
        check("rst_req",   mem_bus.req, 0);
        check("rst_we",    mem_bus.we, 0);
        check("rst_ldata", load_data, 0);
        check("rst_addr",  mem_bus.addr, 0);
        check("rst_be",    mem_bus.be, 0);
        check("rst_wdata", mem_bus.wdata, 0);
        rst = 1'b0;

        // LW, ack in third REQ cycle
        do_op(0, 3'b010, 32'h28, 0, 0, 32'hdeadbeef, 2, rq, lt, a_s, be_s, wd_s, we_s, dn_s, er_s, bz_s);
        check("lw_addr", a_s, 32'h28);
        check("lw_be", be_s, 4'hF);
        check("lw_we", we_s, 0);
        check("lw_reqcyc", rq, 3);
        check("lw_latency", lt, 4);
        check("lw_done", dn_s, 1);
        check("lw_busy_in_done", bz_s, 1);
        check("lw_err", er_s, 0);
        check("lw_data", load_data, 32'hdeadbeef);
        @(negedge clk);
        check("idle_done_low", done, 0);
        check("idle_busy_low", busy, 0);

        // LB / LBU at 0x2B, ack in first REQ cycle
        do_op(0, 3'b000, 32'h28, 3, 0, 32'hdeadbeef, 0, rq, lt, a_s, be_s, wd_s, we_s, dn_s, er_s, bz_s);
        check("lb_be", be_s, 4'h8);
        check("lb_latency", lt, 2);
        check("lb_data", load_data, 32'hffffffde);
        do_op(0, 3'b100, 32'h28, 3, 0, 32'hdeadbeef, 1, rq, lt, a_s, be_s, wd_s, we_s, dn_s, er_s, bz_s);
        check("lbu_data", load_data, 32'h000000de);

        // LH / LHU at 0x2A
        do_op(0, 3'b001, 32'h2A, 0, 0, 32'hdeadbeef, 0, rq, lt, a_s, be_s, wd_s, we_s, dn_s, er_s, bz_s);
        check("lh_addr", a_s, 32'h2A);
        check("lh_be", be_s, 4'hC);
        check("lh_data", load_data, 32'hffffdead);
        do_op(0, 3'b101, 32'h2A, 0, 0, 32'hdeadbeef, 0, rq, lt, a_s, be_s, wd_s, we_s, dn_s, er_s, bz_s);
        check("lhu_data", load_data, 32'h0000dead);

        // SB at 0x29: store must not touch load_data
        do_op(1, 3'b000, 32'h20, 9, 32'h000000a5, 32'h11111111, 0, rq, lt, a_s, be_s, wd_s, we_s, dn_s, er_s, bz_s);
        check("sb_addr", a_s, 32'h29);
        check("sb_we", we_s, 1);
        check("sb_be", be_s, 4'b0010);
        check("sb_wdata", wd_s, 32'h0000a500);
        check("sb_err", er_s, 0);
        check("sb_ldata_kept", load_data, 32'h0000dead);

        // SH at 0x22
        do_op(1, 3'b001, 32'h20, 2, 32'h00001234, 0, 0, rq, lt, a_s, be_s, wd_s, we_s, dn_s, er_s, bz_s);
        check("sh_be", be_s, 4'hC);
        check("sh_wdata", wd_s, 32'h12340000);

        // SW with address wrap
        do_op(1, 3'b010, 32'h0, 32'hfffffffc, 32'hcafef00d, 0, 1, rq, lt, a_s, be_s, wd_s, we_s, dn_s, er_s, bz_s);
        check("sw_wrap_addr", a_s, 32'hfffffffc);
        check("sw_be", be_s, 4'hF);
        check("sw_wdata", wd_s, 32'hcafef00d);

        // Misaligned LW at 0x2A
        do_op(0, 3'b010, 32'h2A, 0, 0, 32'h89abcdef, 0, rq, lt, a_s, be_s, wd_s, we_s, dn_s, er_s, bz_s);
`ifdef LSU_MISALIGN_TRAP_EN
        check("mis_reqcyc", rq, 0);
        check("mis_err", er_s, 1);
        check("mis_ldata_kept", load_data, 32'h0000dead);
`else
        check("mis_addr", a_s, 32'h28);
        check("mis_err", er_s, 0);
        check("mis_data", load_data, 32'h89abcdef);
`endif

        // Timeout: ack never arrives
        do_op(0, 3'b010, 32'h40, 0, 0, 32'h55555555, 1000, rq, lt, a_s, be_s, wd_s, we_s, dn_s, er_s, bz_s);
        check("to_reqcyc", rq, 4);
        check("to_done", dn_s, 1);
        check("to_err", er_s, 1);
`ifdef LSU_MISALIGN_TRAP_EN
        check("to_ldata_kept", load_data, 32'h0000dead);
`else
        check("to_ldata_kept", load_data, 32'h89abcdef);
`endif

        // Illegal funct3 = 111, and a store with a load-only code
        do_op(0, 3'b111, 32'h40, 0, 0, 0, 0, rq, lt, a_s, be_s, wd_s, we_s, dn_s, er_s, bz_s);
        check("ill_latency", lt, 1);
        check("ill_reqcyc", rq, 0);
        check("ill_err", er_s, 1);
        do_op(1, 3'b100, 32'h40, 0, 32'h1, 0, 0, rq, lt, a_s, be_s, wd_s, we_s, dn_s, er_s, bz_s);
        check("ill_st_reqcyc", rq, 0);
        check("ill_st_err", er_s, 1);

        // Reset in the second REQ cycle
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; base = 32'h50; offset = 0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("rstmid_req_before", mem_bus.req, 1);
        #2 rst = 1'b1;
        #1;
        check("rstmid_req_async", mem_bus.req, 0);
        check("rstmid_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        do_op(0, 3'b010, 32'h50, 4, 0, 32'h0badf00d, 1, rq, lt, a_s, be_s, wd_s, we_s, dn_s, er_s, bz_s);
        check("post_rst_addr", a_s, 32'h54);
        check("post_rst_err", er_s, 0);
        check("post_rst_data", load_data, 32'h0badf00d);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Parametrised multicycle load/store datapath block for the RISC-V core. It generalises the word-only load path to the full RV32I/RV64I load/store set: LB/LH/LW/LBU/LHU/SB/SH/SW, plus LD/LWU/SD when XLEN=64. It sits between the control FSM (MEMADR/MEMREAD/MEMWRITE/MEMWB states) and a req/ack data memory port. It performs address generation, byte-lane steering, sign/zero extension, error detection and ack timeout.

Parameters:
XLEN, 32, data/register width; legal values 32 or 64
ADDR_W, 32, byte-address width; must be <= XLEN
MAX_WAIT, 16, maximum REQ cycles without mem_ack before timeout error; 0 disables timeout

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  begin operation; sampled only in IDLE
is_store  in  1  1=store, 0=load
funct3  in  3  RISC-V funct3 access size/signedness
base  in  XLEN  rs1 value
offset  in  XLEN  sign-extended immediate (imm_ext)
store_data  in  XLEN  rs2 value
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle completion pulse
error  out  1  valid with done; illegal funct3, timeout, or misalignment (macro)
load_data  out  XLEN  extended load result; held until next completion
mem_req  out  1  memory request
mem_we  out  1  write enable
mem_addr  out  ADDR_W  byte address
mem_wdata  out  XLEN  lane-shifted store data
mem_be  out  XLEN/8  byte enables
mem_rdata  in  XLEN  read data; valid with mem_ack
mem_ack  in  1  memory completion

Behaviour:
- Reset (async, active-high): state=IDLE. busy, done, error, mem_req, mem_we are 0. load_data, mem_addr, mem_wdata, mem_be, wait counter are 0. Reset mid-operation aborts immediately and mem_req drops asynchronously.
- States: IDLE, REQ, DONE.
- IDLE: on start=1, latch is_store, funct3, store_data and addr=(base+offset) truncated to ADDR_W (wrap-around, no overflow flag).
  - Illegal funct3 (011/110 when XLEN=32; 111 always; 100/101/110 with is_store=1) -> DONE with error=1, no request.
  - Otherwise -> REQ.
  - start while not IDLE is ignored.
- REQ: mem_req=1. mem_addr, mem_we, mem_be and mem_wdata stay stable until ack.
  - mem_ack is sampled each cycle; an ack in the first REQ cycle is legal.
  - On ack: for loads, extract lanes at lane=addr[log2(XLEN/8)-1:0], sign- or zero-extend, and register into load_data. Then -> DONE.
  - Wait counter increments per REQ cycle without ack. If MAX_WAIT!=0 and the counter reaches MAX_WAIT -> DONE with error=1; load_data is unchanged.
- DONE: done=1 and busy=1 for exactly one cycle, then -> IDLE. error is valid only in this cycle and is 0 otherwise.
- Latency: start sampled at cycle T, REQ begins at T+1, ack at cycle A, done at A+1. Best case is done at T+2.
- Store steering: mem_wdata = store_data << (8*lane). mem_be = size mask (1/3/F/FF) << lane.
- Loads also drive mem_be with the same mask; mem_we=0.
- Error on a store means no write occurred.

Optional Feature:
LSU_MISALIGN_TRAP_EN:
- Defined: an access whose address is not naturally aligned (H: addr[0]; W: addr[1:0]; D: addr[2:0]) goes IDLE->DONE with error=1. No mem_req is issued and load_data is unchanged.
- Undefined: low address bits are forced to natural alignment before issue, the access proceeds normally, and misalignment never raises error.

Decomposition:
- Package lsu_pkg: state enum (IDLE/REQ/DONE), funct3 localparams (F3_B/H/W/D/BU/HU/WU), size-mask function.
- Sub-module lsu_lane_align (combinational): store lane shift, byte-enable generation, load extract with sign/zero extension. It is instantiated once in load_store_unit.

Test Plan:
- LW: base=0x28, offset=0, mem_rdata=0xdeadbeef, ack 2 cycles after req -> mem_addr=0x28, mem_be=4'hF, done one cycle after ack, load_data=0xdeadbeef, error=0.
- LB/LBU/LH: addr 0x2B with rdata 0xdeadbeef -> LB=0xffffffde, LBU=0x000000de. LH at 0x2A -> 0xffffdead; LHU -> 0x0000dead.
- SB: base=0x20, offset=9, store_data=0x000000a5 -> mem_we=1, mem_be=4'b0010, mem_wdata=0x0000a500. SW with offset=-4 from 0x0 wraps to mem_addr=0xfffffffc.
- Misaligned LW at 0x2A:
  - With LSU_MISALIGN_TRAP_EN: done with error=1, mem_req never asserted.
  - Without it: mem_addr=0x28 and a normal completion.
- Timeout: MAX_WAIT=4, ack held low -> exactly 4 REQ cycles, then done with error=1 and load_data unchanged. Illegal funct3=111 -> done at T+1 with error=1.
- Reset asserted in the second REQ cycle -> mem_req drops without waiting for clk, busy=0, and a subsequent start completes normally.
